irq_ctrl_gen: RTL and testbench
===============================

Name: irq_ctrl_gen

Overview:
Parametrised interrupt controller, next generation of the system IRQ block. It collects NUM_SOURCES peripheral requests and supports per-source edge/level mode, a non-maskable group, master enable, and auto-clear on acknowledge. It arbitrates by group priority and presents a one-hot priority request plus a vector to the CPU. It sits on the 8-bit system bus at BASE_ADDR and between the peripherals and the CPU core.

Parameters:
NUM_SOURCES, 32, number of request inputs; multiple of 8, 8..32
NUM_GROUPS, 9, number of priority groups; 1..16
PRIO_BITS, 2, priority field width per group; 1..3
GROUP_MAP, 32-source default map packed 4 bits/source (source i at [4i+:4]), group index of each source
NMI_COUNT, 3, sources 0..NMI_COUNT-1 are non-maskable
BASE_ADDR, 24'h2020, bus base address

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clk_ce  in  1  clock enable; all state advances only when high
bus_write  in  1  write strobe
bus_read  in  1  read strobe (informational)
bus_address_in  in  24  bus address
bus_data_in  in  8  write data
bus_data_out  out  8  read data / vector during iack
irqs  in  NUM_SOURCES  raw requests, active high
cpu_iack  in  1  CPU interrupt acknowledge
cpu_irq  out  2**PRIO_BITS-1  one-hot request; bit p-1 means priority p
cpu_nmi  out  1  non-maskable request
irq_vector  out  5  index of winning source

Behaviour:
- Reset (async, reset_n low): all registers 0; cpu_irq=0, cpu_nmi=0, irq_vector=0, bus_data_out=0. Takes effect immediately mid-operation; a pending ack is dropped.
- Register map (offset from BASE_ADDR), bytes little-endian:
  0x00-0x07 PRIO: group g field at bits [PRIO_BITS*g+:PRIO_BITS]; unused bits read 0
  0x08-0x0B ENABLE, one bit per source
  0x0C-0x0F PENDING: read = pending; write 1 clears the bit, write 0 has no effect
  0x10-0x13 MODE: 1 = level, 0 = rising edge
  0x14 CTRL: bit0 master enable, bit1 auto-clear on ack; others read 0
  0x15 STATUS (read-only): {2'b0, irq_vector, cpu_nmi}
  Bytes beyond NUM_SOURCES read 0 and ignore writes.
- Writes commit on the posedge where clk_ce and bus_write are both high.
- Reads are combinational from the address. During cpu_iack, bus_data_out = {2'b0, ack_latch, 1'b0}.
- Capture: irqs registered each clk_ce cycle into irqs_q.
  - Edge source: pending set when irqs & ~irqs_q.
  - Level source: pending set each cycle irqs is high; a clear while high is overridden.
  - Set and clear in the same cycle: set wins.
- Arbitration (combinational over pending & enable):
  - Maskable candidates need CTRL.bit0=1 and group priority > 0.
  - Highest priority wins; on a tie, the lowest source index wins.
- NMI: any pending & enabled source below NMI_COUNT drives cpu_nmi, ignoring CTRL.bit0 and PRIO. NMI takes the vector over maskable sources, lowest index first.
- Outputs registered: cpu_irq/cpu_nmi/irq_vector update one clk_ce cycle after pending changes. Total latency is 2 cycles from the irqs edge to cpu_irq.
- Ack handshake: on the first clk_ce cycle cpu_iack is high (rising edge detected), ack_latch <= irq_vector. If CTRL.bit1, the pending bit of that source clears in the same cycle, unless it is re-set per the set-wins rule. ack_latch holds while cpu_iack stays high.
- No candidate: cpu_irq=0, cpu_nmi=0, irq_vector holds its last value.

Test Plan:
- Reset/readback: write PRIO 0x00=8'hE4 and ENABLE 0x08=8'hFF, then read back 8'hE4 and 8'hFF. Pulse reset_n low → all reads 0 and cpu_irq=0 immediately.
- Edge capture + latency: MODE=0, CTRL=1, source 3 in group 3 with priority 2, enabled. Pulse irqs[3] for one cycle → PENDING bit3=1; cpu_irq=3'b010 two cycles after the edge; irq_vector=3.
- Tie-break: sources 5 and 6 share group priority 3, both pending → irq_vector=5. Clear bit5 via write 8'h20 to 0x0C → irq_vector=6 one cycle later.
- Level + set-wins: MODE bit7=1, hold irqs[7] high, write clear → PENDING bit7 stays 1. Drop irqs[7], then clear → bit7=0.
- Ack auto-clear: CTRL=8'h03, source 4 pending, assert cpu_iack → bus_data_out=8'h08 and PENDING bit4=0 the next cycle. With CTRL=8'h01, bit4 stays 1.
- NMI: CTRL=0, PRIO=0, source 1 enabled and pending → cpu_nmi=1, cpu_irq=0, irq_vector=1.

Source files
------------

// File: rtl/irq_ctrl_gen.sv
// irq_ctrl_gen: bus-programmable interrupt controller with edge/level capture,
// group-priority arbitration, non-maskable sources and auto-clearing acknowledge.
module irq_ctrl_gen #(
  parameter int           NUM_SOURCES = 32,
  parameter int           NUM_GROUPS  = 9,
  parameter int           PRIO_BITS   = 2,
  parameter logic [127:0] GROUP_MAP   = 128'h43210876_54321087_65432108_76543210,
  parameter int           NMI_COUNT   = 3,
  parameter logic [23:0]  BASE_ADDR   = 24'h002020
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clk_ce,
  input  logic                     bus_write,
  input  logic                     bus_read,
  input  logic [23:0]              bus_address_in,
  input  logic [7:0]               bus_data_in,
  output logic [7:0]               bus_data_out,
  input  logic [NUM_SOURCES-1:0]   irqs,
  input  logic                     cpu_iack,
  output logic [2**PRIO_BITS-2:0]  cpu_irq,
  output logic                     cpu_nmi,
  output logic [4:0]               irq_vector
);

  localparam int PRIO_W = NUM_GROUPS * PRIO_BITS;
  localparam int IRQ_W  = 2**PRIO_BITS - 1;

  logic [PRIO_W-1:0]      prio_reg;
  logic [NUM_SOURCES-1:0] enable_reg;
  logic [NUM_SOURCES-1:0] pending_reg;
  logic [NUM_SOURCES-1:0] mode_reg;
  logic [NUM_SOURCES-1:0] irqs_q;
  logic [1:0]             ctrl_reg;
  logic                   iack_q;
  logic [4:0]             ack_latch;

  logic [23:0] addr_off;
  logic        addr_hit;
  logic [4:0]  reg_off;
  logic        wr_en;
  logic        bus_read_unused;

  assign addr_off        = bus_address_in - BASE_ADDR;
  assign addr_hit        = addr_off < 24'h16;
  assign reg_off         = addr_off[4:0];
  assign wr_en           = bus_write && addr_hit;
  assign bus_read_unused = bus_read;

  logic [PRIO_W-1:0]      prio_next;
  logic [NUM_SOURCES-1:0] enable_next;
  logic [NUM_SOURCES-1:0] mode_next;
  logic [NUM_SOURCES-1:0] wr_clear;
  logic [NUM_SOURCES-1:0] ack_clear;
  logic [NUM_SOURCES-1:0] set_mask;
  logic [NUM_SOURCES-1:0] pending_next;
  logic                   ack_fire;

  always_comb begin
    prio_next   = prio_reg;
    enable_next = enable_reg;
    mode_next   = mode_reg;
    wr_clear    = '0;
    for (int b = 0; b < PRIO_W; b++)
      if (wr_en && reg_off[4:3] == 2'b00 && reg_off[2:0] == 3'(b / 8))
        prio_next[b] = bus_data_in[3'(b % 8)];
    for (int b = 0; b < NUM_SOURCES; b++) begin
      if (wr_en && reg_off[1:0] == 2'(b / 8)) begin
        case (reg_off[4:2])
          3'b010:  enable_next[b] = bus_data_in[3'(b % 8)];
          3'b011:  wr_clear[b]    = bus_data_in[3'(b % 8)];
          3'b100:  mode_next[b]   = bus_data_in[3'(b % 8)];
          default: ;
        endcase
      end
    end
  end

  // New requests are ORed in after clears so a source that is still asserting wins.
  assign ack_fire     = cpu_iack && !iack_q;
  assign set_mask     = (mode_reg & irqs) | (~mode_reg & irqs & ~irqs_q);
  assign ack_clear    = (ack_fire && ctrl_reg[1]) ? (NUM_SOURCES'(1) << irq_vector) : '0;
  assign pending_next = (pending_reg & ~(wr_clear | ack_clear)) | set_mask;

  logic [63:0]          prio_pad;
  logic [PRIO_BITS-1:0] src_prio [NUM_SOURCES];
  logic [PRIO_BITS-1:0] best_prio;
  logic [4:0]           best_idx;
  logic [4:0]           nmi_idx;
  logic                 nmi_hit;
  logic [IRQ_W-1:0]     irq_onehot;

  assign prio_pad = 64'(prio_reg);

  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++)
      src_prio[i] = (int'(GROUP_MAP[4*i +: 4]) < NUM_GROUPS)
                    ? prio_pad[PRIO_BITS*int'(GROUP_MAP[4*i +: 4]) +: PRIO_BITS] : '0;
  end

  // Ascending scan with strict compare keeps the lowest index on priority ties.
  always_comb begin
    best_prio = '0;
    best_idx  = '0;
    nmi_hit   = 1'b0;
    nmi_idx   = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (pending_reg[i] && enable_reg[i]) begin
        if (i < NMI_COUNT) begin
          if (!nmi_hit) begin
            nmi_hit = 1'b1;
            nmi_idx = 5'(i);
          end
        end else if (ctrl_reg[0] && src_prio[i] > best_prio) begin
          best_prio = src_prio[i];
          best_idx  = 5'(i);
        end
      end
    end
  end

  always_comb begin
    irq_onehot = '0;
    for (int p = 1; p <= IRQ_W; p++)
      if (best_prio == PRIO_BITS'(p)) irq_onehot[p-1] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_reg    <= '0;
      enable_reg  <= '0;
      pending_reg <= '0;
      mode_reg    <= '0;
      irqs_q      <= '0;
      ctrl_reg    <= '0;
      iack_q      <= 1'b0;
      ack_latch   <= '0;
      cpu_irq     <= '0;
      cpu_nmi     <= 1'b0;
      irq_vector  <= '0;
    end else if (clk_ce) begin
      prio_reg    <= prio_next;
      enable_reg  <= enable_next;
      mode_reg    <= mode_next;
      pending_reg <= pending_next;
      irqs_q      <= irqs;
      iack_q      <= cpu_iack;
      if (wr_en && reg_off == 5'h14) ctrl_reg <= bus_data_in[1:0];
      if (ack_fire) ack_latch <= irq_vector;
      cpu_irq <= irq_onehot;
      cpu_nmi <= nmi_hit;
      if (nmi_hit) irq_vector <= nmi_idx;
      else if (best_prio != '0) irq_vector <= best_idx;
    end
  end

  logic [31:0] enable_pad;
  logic [31:0] pending_pad;
  logic [31:0] mode_pad;

  assign enable_pad  = 32'(enable_reg);
  assign pending_pad = 32'(pending_reg);
  assign mode_pad    = 32'(mode_reg);

  always_comb begin
    bus_data_out = '0;
    if (cpu_iack) begin
      bus_data_out = {2'b00, ack_latch, 1'b0};
    end else if (addr_hit) begin
      case (reg_off[4:2])
        3'b000, 3'b001: bus_data_out = prio_pad[{reg_off[2:0], 3'b000} +: 8];
        3'b010:         bus_data_out = enable_pad[{reg_off[1:0], 3'b000} +: 8];
        3'b011:         bus_data_out = pending_pad[{reg_off[1:0], 3'b000} +: 8];
        3'b100:         bus_data_out = mode_pad[{reg_off[1:0], 3'b000} +: 8];
        3'b101: begin
          if (reg_off[1:0] == 2'b00)      bus_data_out = {6'b0, ctrl_reg};
          else if (reg_off[1:0] == 2'b01) bus_data_out = {2'b00, irq_vector, cpu_nmi};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl_gen.sv
// Bench for irq_ctrl_gen: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model of the controller.
module tb_irq_ctrl_gen;

  localparam int          N    = 32;
  localparam logic [23:0] BASE = 24'h002020;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_ce = 1'b0;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [23:0] bus_address_in = BASE;
  logic [7:0]  bus_data_in = 8'h00;
  logic [N-1:0] irqs = '0;
  logic        cpu_iack = 1'b0;
  logic [7:0]  bus_data_out;
  logic [2:0]  cpu_irq;
  logic        cpu_nmi;
  logic [4:0]  irq_vector;

  int total = 0;
  int bad   = 0;

  irq_ctrl_gen dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clk_ce         (clk_ce),
    .bus_write      (bus_write),
    .bus_read       (bus_read),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_data_out   (bus_data_out),
    .irqs           (irqs),
    .cpu_iack       (cpu_iack),
    .cpu_irq        (cpu_irq),
    .cpu_nmi        (cpu_nmi),
    .irq_vector     (irq_vector)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Behavioural model state; default group map places source i in group i % 9.
  bit m_pend [N];
  bit m_en   [N];
  bit m_mode [N];
  bit m_prev [N];
  int m_prio [9];
  bit m_master, m_autoclr, m_iack_prev, m_nmi;
  int m_vec, m_irq, m_latch;

  function automatic logic [63:0] prio_word();
    logic [63:0] v = '0;
    for (int g = 0; g < 9; g++) v = v | (64'(m_prio[g]) << (2 * g));
    return v;
  endfunction

  function automatic void arbitrate(output bit nmi, output int nsrc, output int best, output int bsrc);
    nmi = 0; nsrc = 0; best = 0; bsrc = 0;
    for (int i = 2; i >= 0; i--)
      if (m_pend[i] && m_en[i]) begin nmi = 1; nsrc = i; end
    if (m_master)
      for (int i = 3; i < N; i++)
        if (m_pend[i] && m_en[i] && m_prio[i % 9] > best) best = m_prio[i % 9];
    for (int i = N - 1; i >= 3; i--)
      if (best > 0 && m_master && m_pend[i] && m_en[i] && m_prio[i % 9] == best) bsrc = i;
  endfunction

  function automatic logic [7:0] model_read();
    logic [63:0] v;
    int off, sel;
    if (cpu_iack) return {2'b00, 5'(m_latch), 1'b0};
    if (bus_address_in < BASE || bus_address_in > BASE + 24'h15) return 8'h00;
    off = int'(bus_address_in - BASE);
    if (off < 8) begin
      v = prio_word();
      return v[8*off +: 8];
    end
    if (off < 20) begin
      v = '0;
      sel = (off - 8) / 4;
      for (int i = 0; i < N; i++)
        v[i] = (sel == 0) ? m_en[i] : (sel == 1) ? m_pend[i] : m_mode[i];
      return v[8*((off - 8) % 4) +: 8];
    end
    if (off == 20) return {6'b0, m_autoclr, m_master};
    return {2'b00, 5'(m_vec), m_nmi};
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit nmi, hit, ack, set_b, clr_b;
    int nsrc, best, bsrc, off;
    logic [63:0] v;
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] <= 0; m_en[i] <= 0; m_mode[i] <= 0; m_prev[i] <= 0;
      end
      for (int g = 0; g < 9; g++) m_prio[g] <= 0;
      m_master <= 0; m_autoclr <= 0; m_iack_prev <= 0; m_nmi <= 0;
      m_vec <= 0; m_irq <= 0; m_latch <= 0;
    end else if (clk_ce) begin
      arbitrate(nmi, nsrc, best, bsrc);
      hit = bus_write && bus_address_in >= BASE && bus_address_in <= BASE + 24'h15;
      off = int'(bus_address_in - BASE);
      ack = cpu_iack && !m_iack_prev;
      for (int i = 0; i < N; i++) begin
        set_b = m_mode[i] ? irqs[i] : (irqs[i] && !m_prev[i]);
        clr_b = (hit && off == 12 + i / 8 && bus_data_in[i % 8]) || (ack && m_autoclr && i == m_vec);
        m_pend[i] <= set_b || (m_pend[i] && !clr_b);
        m_prev[i] <= irqs[i];
        if (hit && off == 8 + i / 8)  m_en[i]   <= bus_data_in[i % 8];
        if (hit && off == 16 + i / 8) m_mode[i] <= bus_data_in[i % 8];
      end
      if (hit && off < 8) begin
        v = prio_word();
        v[8*off +: 8] = bus_data_in;
        for (int g = 0; g < 9; g++) m_prio[g] <= int'((v >> (2 * g)) & 64'd3);
      end
      if (hit && off == 20) begin
        m_master  <= bus_data_in[0];
        m_autoclr <= bus_data_in[1];
      end
      m_iack_prev <= cpu_iack;
      if (ack) m_latch <= m_vec;
      m_nmi <= nmi;
      m_irq <= (best > 0) ? (1 << (best - 1)) : 0;
      if (nmi) m_vec <= nsrc;
      else if (best > 0) m_vec <= bsrc;
    end
  end

  always @(negedge clk) begin
    check_output("cmp_cpu_irq", 32'(cpu_irq), m_irq);
    check_output("cmp_cpu_nmi", 32'(cpu_nmi), 32'(m_nmi));
    check_output("cmp_irq_vector", 32'(irq_vector), m_vec);
    check_output("cmp_bus_data_out", 32'(bus_data_out), 32'(model_read()));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_wr(input logic [7:0] off, input logic [7:0] d);
    bus_address_in = BASE + 24'(off);
    bus_data_in    = d;
    bus_write      = 1'b1;
    tick();
    bus_write      = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] off, output logic [7:0] d);
    bus_address_in = BASE + 24'(off);
    bus_read       = 1'b1;
    #1;
    d        = bus_data_out;
    bus_read = 1'b0;
  endtask

  task automatic pulse_irq(input int src);
    irqs[src] = 1'b1;
    tick();
    irqs[src] = 1'b0;
  endtask

  task automatic apply_stimulus();
    reset_n        = ($urandom_range(0, 799) != 0);
    clk_ce         = ($urandom_range(0, 7) != 0);
    irqs           = irqs ^ ($urandom & $urandom & $urandom);
    cpu_iack       = ($urandom_range(0, 5) == 0) ? ~cpu_iack : cpu_iack;
    bus_write      = ($urandom_range(0, 3) == 0);
    bus_read       = ~bus_write;
    bus_address_in = ($urandom_range(0, 7) != 0) ? BASE + 24'($urandom_range(0, 23)) : 24'($urandom);
    bus_data_in    = 8'($urandom);
    tick();
  endtask

  initial begin
    logic [7:0] rd;
    clk_ce  = 1'b1;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check_output("rst_cpu_irq", 32'(cpu_irq), 32'h0);
    check_output("rst_cpu_nmi", 32'(cpu_nmi), 32'h0);
    check_output("rst_vector", 32'(irq_vector), 32'h0);
    bus_rd(8'h00, rd);
    check_output("rst_prio_read", 32'(rd), 32'h0);

    bus_wr(8'h00, 8'hE4);
    bus_wr(8'h08, 8'hFF);
    bus_rd(8'h00, rd);
    check_output("prio_readback", 32'(rd), 32'hE4);
    bus_rd(8'h08, rd);
    check_output("enable_readback", 32'(rd), 32'hFF);
    tick();
    reset_n = 1'b0;
    bus_rd(8'h00, rd);
    check_output("midrst_prio", 32'(rd), 32'h0);
    bus_rd(8'h08, rd);
    check_output("midrst_enable", 32'(rd), 32'h0);
    check_output("midrst_cpu_irq", 32'(cpu_irq), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    bus_wr(8'h14, 8'h01);
    bus_wr(8'h00, 8'h80);
    bus_wr(8'h08, 8'h08);
    pulse_irq(3);
    bus_rd(8'h0C, rd);
    check_output("edge_pending", 32'(rd), 32'h08);
    check_output("edge_irq_early", 32'(cpu_irq), 32'h0);
    tick();
    check_output("edge_cpu_irq", 32'(cpu_irq), 32'h2);
    check_output("edge_vector", 32'(irq_vector), 32'd3);
    bus_wr(8'h0C, 8'h08);
    tick();
    check_output("idle_cpu_irq", 32'(cpu_irq), 32'h0);
    check_output("idle_vector_hold", 32'(irq_vector), 32'd3);

    bus_wr(8'h01, 8'h3C);
    bus_wr(8'h08, 8'h68);
    irqs[5] = 1'b1;
    irqs[6] = 1'b1;
    tick();
    irqs = '0;
    tick();
    check_output("tie_vector", 32'(irq_vector), 32'd5);
    check_output("tie_cpu_irq", 32'(cpu_irq), 32'h4);
    bus_wr(8'h0C, 8'h20);
    tick();
    check_output("tie_after_clear", 32'(irq_vector), 32'd6);
    bus_wr(8'h0C, 8'h40);
    tick();

    bus_wr(8'h10, 8'h80);
    irqs[7] = 1'b1;
    tick();
    tick();
    bus_wr(8'h0C, 8'h80);
    bus_rd(8'h0C, rd);
    check_output("level_set_wins", 32'(rd), 32'h80);
    irqs[7] = 1'b0;
    tick();
    bus_wr(8'h0C, 8'h80);
    bus_rd(8'h0C, rd);
    check_output("level_cleared", 32'(rd), 32'h00);
    bus_wr(8'h10, 8'h00);

    bus_wr(8'h14, 8'h03);
    bus_wr(8'h01, 8'h3D);
    bus_wr(8'h08, 8'h10);
    pulse_irq(4);
    tick();
    check_output("ack_vector", 32'(irq_vector), 32'd4);
    check_output("ack_cpu_irq", 32'(cpu_irq), 32'h1);
    cpu_iack = 1'b1;
    tick();
    check_output("ack_bus_vector", 32'(bus_data_out), 32'h08);
    cpu_iack = 1'b0;
    bus_rd(8'h0C, rd);
    check_output("ack_autoclear", 32'(rd), 32'h00);
    bus_wr(8'h14, 8'h01);
    pulse_irq(4);
    tick();
    cpu_iack = 1'b1;
    tick();
    cpu_iack = 1'b0;
    bus_rd(8'h0C, rd);
    check_output("ack_no_autoclear", 32'(rd), 32'h10);
    bus_wr(8'h0C, 8'h10);

    bus_wr(8'h14, 8'h00);
    bus_wr(8'h00, 8'h00);
    bus_wr(8'h01, 8'h00);
    bus_wr(8'h08, 8'h02);
    pulse_irq(1);
    tick();
    check_output("nmi_flag", 32'(cpu_nmi), 32'h1);
    check_output("nmi_cpu_irq", 32'(cpu_irq), 32'h0);
    check_output("nmi_vector", 32'(irq_vector), 32'd1);
    bus_rd(8'h15, rd);
    check_output("nmi_status", 32'(rd), 32'h03);
    bus_wr(8'h0C, 8'h02);
    tick();

    $display("[TB] directed phase complete, starting random traffic");
    for (int c = 0; c < 2500; c++) apply_stimulus();

    reset_n   = 1'b1;
    clk_ce    = 1'b1;
    bus_write = 1'b0;
    cpu_iack  = 1'b0;
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
